// File: rtl/bist_resp_analyzer_if.sv
// Handshake and status bundle between a BIST response source and the analyzer.
// The source side (master) drives start/valid/resp; the analyzer (slave) reports status.
interface bist_resp_analyzer_if;
    logic        start;
    logic        in_valid;
    logic [15:0] resp;
    logic        in_ready;
    logic [15:0] sig;
    logic [7:0]  count;
    logic        busy;
    logic        done;
    logic        pass;

    modport master (
        output start, in_valid, resp,
        input  in_ready, sig, count, busy, done, pass
    );

    modport slave (
        input  start, in_valid, resp,
        output in_ready, sig, count, busy, done, pass
    );
endinterface

// File: rtl/bist_resp_analyzer.sv
// Compacts NPAT multiplier responses into a 16-bit MISR signature and
// compares the final signature against GOLDEN.
module bist_resp_analyzer #(
    parameter int unsigned NPAT   = 255,
    parameter logic [15:0] SEED   = 16'hFFFF,
    parameter logic [15:0] GOLDEN = 16'hFFFE
) (
    input logic                   clk,
    input logic                   rst,
    bist_resp_analyzer_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

    localparam logic [7:0] LAST_CNT = 8'(NPAT - 1);

    state_t      state_q, state_d;
    logic [15:0] sig_q,   sig_d;
    logic [7:0]  count_q, count_d;
    logic        done_q,  done_d;
    logic        pass_q,  pass_d;
    logic        accept;

    // Polynomial x^16 + x^15 + x^13 + x^4 + 1, response folded in after the shift.
    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] r);
        logic fb;
        fb = s[15] ^ s[14] ^ s[12] ^ s[3];
        return {s[14:0], fb} ^ r;
    endfunction

    assign accept = bus.in_valid && (state_q == RUN);

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        count_d = count_q;
        done_d  = done_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    sig_d   = SEED;
                    count_d = 8'd0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                if (accept) begin
                    sig_d   = misr_step(sig_q, bus.resp);
                    count_d = count_q + 8'd1;
                    if (count_q == LAST_CNT) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                pass_d  = (sig_q == GOLDEN);
                done_d  = 1'b1;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            count_q <= 8'd0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            count_q <= count_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.in_ready = (state_q == RUN);
    assign bus.busy     = (state_q == RUN) || (state_q == CHECK);
    assign bus.sig      = sig_q;
    assign bus.count    = count_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;

endmodule

// File: tb/tb_bist_resp_analyzer.sv
// Bench for bist_resp_analyzer: single-beat runs from a vector table on an NPAT=1
// instance, and scoreboarded multi-beat runs on an NPAT=3 instance.
module tb_bist_resp_analyzer;

    logic clk;
    logic rst;

    bist_resp_analyzer_if ifa ();
    bist_resp_analyzer_if ifb ();

    bist_resp_analyzer #(.NPAT(1), .SEED(16'hFFFF), .GOLDEN(16'hFFFE)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    bist_resp_analyzer #(.NPAT(3), .SEED(16'hFFFF), .GOLDEN(16'hFFF8)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    typedef struct {
        logic [15:0] resp;
        logic [15:0] exp_sig;
        logic        exp_pass;
    } vec_t;

    typedef struct {
        logic [15:0] sig;
        logic [7:0]  cnt;
    } exp_t;

    int          n_vec  = 0;
    int          n_fail = 0;
    exp_t        sbq[$];
    logic [15:0] m_sig;
    logic [7:0]  m_cnt;
    vec_t        tbl[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] model_misr(input logic [15:0] s, input logic [15:0] r);
        logic fb;
        fb = s[15] ^ s[14] ^ s[12] ^ s[3];
        return {s[14:0], fb} ^ r;
    endfunction

    // Scoreboard monitor for the NPAT=3 instance: every accept pops one expectation.
    always @(posedge clk) begin
        if (!rst && ifb.in_valid && ifb.in_ready) begin
            #1;
            if (sbq.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL sb_unexpected: got accept expected none");
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_sig", 32'(ifb.sig), 32'(e.sig));
                chk("sb_cnt", 32'(ifb.count), 32'(e.cnt));
            end
        end
    end

    task automatic b_accept(input logic [15:0] r, input int gap);
        exp_t e;
        m_sig = model_misr(m_sig, r);
        m_cnt = m_cnt + 8'd1;
        e.sig = m_sig;
        e.cnt = m_cnt;
        sbq.push_back(e);
        ifb.in_valid = 1'b1;
        ifb.resp     = r;
        tick();
        ifb.in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            ifb.resp = 16'($urandom);
            tick();
            chk("hold_sig", 32'(ifb.sig), 32'(m_sig));
            chk("hold_cnt", 32'(ifb.count), 32'(m_cnt));
        end
    endtask

    task automatic b_start();
        ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
        m_sig = 16'hFFFF;
        m_cnt = 8'd0;
        chk("b_start_sig", 32'(ifb.sig), 32'hFFFF);
        chk("b_start_ready", 32'(ifb.in_ready), 32'd1);
    endtask

    task automatic b_wait_done();
        int cyc;
        cyc = 0;
        while (ifb.done !== 1'b1 && cyc < 8) begin
            tick();
            cyc++;
        end
        chk("b_done_seen", 32'(ifb.done), 32'd1);
    endtask

    initial begin
        tbl[0] = '{resp: 16'h0000, exp_sig: 16'hFFFE, exp_pass: 1'b1};
        tbl[1] = '{resp: 16'h0001, exp_sig: 16'hFFFF, exp_pass: 1'b0};
        tbl[2] = '{resp: 16'h1234, exp_sig: 16'hEDCA, exp_pass: 1'b0};
        tbl[3] = '{resp: 16'h0000, exp_sig: 16'hFFFE, exp_pass: 1'b1};

        rst = 1'b1;
        ifa.start = 1'b0; ifa.in_valid = 1'b0; ifa.resp = 16'h0;
        ifb.start = 1'b0; ifb.in_valid = 1'b0; ifb.resp = 16'h0;
        m_sig = 16'hFFFF;
        m_cnt = 8'd0;
        tick();
        rst = 1'b0;

        chk("rst_sig", 32'(ifa.sig), 32'hFFFF);
        chk("rst_cnt", 32'(ifa.count), 32'd0);
        chk("rst_ready", 32'(ifa.in_ready), 32'd0);
        chk("rst_busy", 32'(ifa.busy), 32'd0);
        chk("rst_done", 32'(ifa.done), 32'd0);
        chk("rst_pass", 32'(ifa.pass), 32'd0);
        chk("rst_b_sig", 32'(ifb.sig), 32'hFFFF);

        // Responses arriving while idle must be ignored.
        ifa.in_valid = 1'b1; ifa.resp = 16'h5A5A;
        tick();
        ifa.in_valid = 1'b0;
        chk("idle_ignore_sig", 32'(ifa.sig), 32'hFFFF);
        chk("idle_ignore_cnt", 32'(ifa.count), 32'd0);

        for (int i = 0; i < 4; i++) begin
            ifa.start = 1'b1;
            tick();
            ifa.start = 1'b0;
            chk("a_start_sig", 32'(ifa.sig), 32'hFFFF);
            chk("a_start_cnt", 32'(ifa.count), 32'd0);
            chk("a_start_ready", 32'(ifa.in_ready), 32'd1);
            chk("a_start_busy", 32'(ifa.busy), 32'd1);
            chk("a_start_done", 32'(ifa.done), 32'd0);
            chk("a_start_pass", 32'(ifa.pass), 32'd0);
            ifa.in_valid = 1'b1;
            ifa.resp     = tbl[i].resp;
            tick();
            ifa.in_valid = 1'b0;
            chk("a_acc_sig", 32'(ifa.sig), 32'(tbl[i].exp_sig));
            chk("a_acc_cnt", 32'(ifa.count), 32'd1);
            chk("a_check_ready", 32'(ifa.in_ready), 32'd0);
            chk("a_check_busy", 32'(ifa.busy), 32'd1);
            chk("a_check_done", 32'(ifa.done), 32'd0);
            tick();
            chk("a_done", 32'(ifa.done), 32'd1);
            chk("a_pass", 32'(ifa.pass), 32'(tbl[i].exp_pass));
            chk("a_done_busy", 32'(ifa.busy), 32'd0);
            ifa.in_valid = 1'b1; ifa.resp = 16'hFFFF;
            tick();
            ifa.in_valid = 1'b0;
            chk("a_done_hold_sig", 32'(ifa.sig), 32'(tbl[i].exp_sig));
            chk("a_done_hold_cnt", 32'(ifa.count), 32'd1);
            chk("a_done_hold_done", 32'(ifa.done), 32'd1);
            chk("a_done_hold_pass", 32'(ifa.pass), 32'(tbl[i].exp_pass));
        end

        // Gapped stream of zeros: FFFE, FFFC, FFF8 and a passing signature.
        b_start();
        b_accept(16'h0000, 2);
        chk("gap_sig1", 32'(ifb.sig), 32'hFFFE);
        b_accept(16'h0000, 2);
        chk("gap_sig2", 32'(ifb.sig), 32'hFFFC);
        b_accept(16'h0000, 0);
        chk("gap_ready_drop", 32'(ifb.in_ready), 32'd0);
        chk("gap_sig3", 32'(ifb.sig), 32'hFFF8);
        chk("gap_cnt3", 32'(ifb.count), 32'd3);
        b_wait_done();
        chk("gap_pass", 32'(ifb.pass), 32'd1);

        // Start during RUN is ignored; reset wins over start and valid.
        b_start();
        chk("b_restart_done", 32'(ifb.done), 32'd0);
        chk("b_restart_pass", 32'(ifb.pass), 32'd0);
        b_accept(16'h00A5, 0);
        ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
        chk("run_start_cnt", 32'(ifb.count), 32'd1);
        chk("run_start_sig", 32'(ifb.sig), 32'(m_sig));
        chk("run_start_busy", 32'(ifb.busy), 32'd1);
        rst = 1'b1; ifb.start = 1'b1; ifb.in_valid = 1'b1; ifb.resp = 16'h1111;
        tick();
        rst = 1'b0; ifb.start = 1'b0; ifb.in_valid = 1'b0;
        chk("mid_rst_sig", 32'(ifb.sig), 32'hFFFF);
        chk("mid_rst_cnt", 32'(ifb.count), 32'd0);
        chk("mid_rst_ready", 32'(ifb.in_ready), 32'd0);
        chk("mid_rst_busy", 32'(ifb.busy), 32'd0);
        chk("mid_rst_done", 32'(ifb.done), 32'd0);
        chk("mid_rst_pass", 32'(ifb.pass), 32'd0);
        tick();
        chk("mid_rst_stays_idle", 32'(ifb.in_ready), 32'd0);

        // Fresh run from SEED with random responses.
        b_start();
        for (int k = 0; k < 3; k++) begin
            b_accept(16'($urandom), 1);
        end
        b_wait_done();
        chk("rand_sig", 32'(ifb.sig), 32'(m_sig));
        chk("rand_pass", 32'(ifb.pass), 32'(m_sig == 16'hFFF8));

        // Reset while in CHECK cancels the pending verdict.
        b_start();
        b_accept(16'h0000, 0);
        b_accept(16'h0000, 0);
        b_accept(16'h0000, 0);
        chk("chk_state_busy", 32'(ifb.busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("chk_rst_done", 32'(ifb.done), 32'd0);
        chk("chk_rst_busy", 32'(ifb.busy), 32'd0);
        chk("chk_rst_sig", 32'(ifb.sig), 32'hFFFF);
        tick();
        chk("chk_rst_done2", 32'(ifb.done), 32'd0);

        chk("sb_drain", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/bist_resp_analyzer.md
BIST_RESP_ANALYZER -- requirements
Module: bist_resp_analyzer

Interface
REQ-001 SHALL have parameter NPAT, default 255, meaning the number of responses compacted per run (legal range 1..255).
REQ-002 SHALL have parameter SEED, default 16'hFFFF, meaning the MISR initial value.
REQ-003 SHALL have parameter GOLDEN, default 16'hFFFE, meaning the expected final signature.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 start  input  1  begin a run; sampled per REQ-013.
REQ-007 in_valid  input  1  resp carries a multiplier output this cycle.
REQ-008 resp  input  16  approximate product from the unit under test.
REQ-009 in_ready  output  1  analyzer accepts resp this cycle.
REQ-010 sig  output  16  current MISR signature (registered).
REQ-011 count  output  8  responses accepted in current run (registered).
REQ-012 busy, done, pass  outputs  1 each  run in progress / run complete / final sig == GOLDEN.

Function
REQ-013 FSM states SHALL be IDLE, RUN, CHECK and DONE.
- IDLE->RUN on start.
- DONE->RUN on start.
- start in RUN or CHECK ignored.
REQ-014 On the IDLE->RUN or DONE->RUN edge, the block SHALL:
- load sig<=SEED and count<=0;
- clear done and pass.
REQ-015 in_ready SHALL equal 1 only in RUN (combinational from state); busy SHALL be 1 in RUN and CHECK.
REQ-016 An accept SHALL occur when in_valid && in_ready at a rising edge; only accepts change sig and count.
REQ-017 MISR update per accept:
- fb = sig[15]^sig[14]^sig[12]^sig[3] (polynomial x^16+x^15+x^13+x^4+1);
- sig <= {sig[14:0], fb} ^ resp;
- count <= count+1.
REQ-018 Cycles with in_valid low in RUN SHALL hold sig and count unchanged; there is no timeout.
REQ-019 The accept that makes count reach NPAT SHALL move RUN->CHECK on the same edge; in_ready drops the following cycle.
REQ-020 The edge after entering CHECK SHALL perform, in one edge:
- pass <= (sig == GOLDEN);
- done <= 1;
- state <= DONE.
REQ-020 latency: done rises on the second rising edge after the final accept.
REQ-021 In DONE, sig, count, pass and done SHALL hold until rst or start.
REQ-022 count SHALL never exceed NPAT; no wrap-around occurs in a legal configuration.
REQ-023 resp values received outside RUN SHALL be ignored regardless of in_valid.

Reset
REQ-024 rst=1 at a rising edge SHALL, from any state (including mid-RUN or CHECK):
- force state IDLE;
- set sig=SEED, count=0;
- set in_ready=0, busy=0, done=0, pass=0.
REQ-025 rst SHALL take priority over start and in_valid in the same cycle.
REQ-026 The block SHALL be fully defined one cycle after rst deasserts; no asynchronous paths.

Verification
REQ-027 Reset check: rst high 1 cycle -> sig=16'hFFFF, count=0, in_ready=0, busy=0, done=0, pass=0.
REQ-028 Single-beat pass: NPAT=1, GOLDEN=16'hFFFE, start, then resp=16'h0000 with in_valid -> sig=16'hFFFE, done=1 two edges after accept, pass=1.
REQ-029 Single-beat fail: NPAT=1, GOLDEN=16'hFFFE, resp=16'h0001 -> sig=16'hFFFF, done=1, pass=0.
REQ-030 Gapped stream: NPAT=3, GOLDEN=16'hFFF8, three resp=16'h0000 accepts with 2 idle cycles between each -> sig sequence FFFE, FFFC, FFF8; count 1,2,3; pass=1.
REQ-031 Ignored start and mid-run reset:
- start pulsed in RUN after 1 accept -> count stays 1;
- then rst -> IDLE with all REQ-024 values;
- a subsequent start produces a fresh run from SEED.
REQ-032 Restart from DONE: after REQ-028 completes, start -> done=0, pass=0, sig=16'hFFFF, count=0, in_ready=1 the next cycle.
